// File: rtl/health_tracker.sv
// Two-fighter health tracker: edge-detected hits, per-frame hit immunity,
// sticky death, and Restart/Reset recovery. Everything runs on Clk.

module health_tracker_fighter #(
    parameter logic [6:0] MAX_HEALTH    = 7'd100,
    parameter logic [6:0] DAMAGE        = 7'd10,
    parameter logic [5:0] INVULN_FRAMES = 6'd30
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_restart,
    input  logic       i_battle,
    input  logic       i_frame_tick,
    input  logic       i_hit,
    output logic [6:0] o_health,
    output logic       o_dead,
    output logic       o_invuln
);
    localparam int unsigned HEALTH_W = 7;
    localparam int unsigned CNT_W    = 6;

    logic                r_hit_q;
    logic [HEALTH_W-1:0] r_health;
    logic                r_dead;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_invuln;

    logic                w_hit_edge;
    logic                w_counted;
    logic [HEALTH_W-1:0] w_damaged;
    logic [HEALTH_W-1:0] w_nxt_health;
    logic                w_nxt_dead;
    logic [CNT_W-1:0]    w_nxt_cnt;

    assign w_hit_edge = i_hit & ~r_hit_q;
    assign w_counted  = w_hit_edge & i_battle & ~r_dead & (r_cnt == '0) & ~i_restart;
    // Saturate at zero instead of wrapping
    assign w_damaged  = (r_health >= DAMAGE) ? HEALTH_W'(r_health - DAMAGE) : '0;

    // Next state: restart beats a hit, a hit's reload beats a frame decrement
    always_comb begin
        w_nxt_health = r_health;
        w_nxt_dead   = r_dead;
        w_nxt_cnt    = r_cnt;
        if (i_restart) begin
            w_nxt_health = MAX_HEALTH;
            w_nxt_dead   = 1'b0;
            w_nxt_cnt    = '0;
        end else if (w_counted) begin
            w_nxt_health = w_damaged;
            w_nxt_dead   = (w_damaged == '0);
            w_nxt_cnt    = INVULN_FRAMES;
        end else if (i_frame_tick && (r_cnt != '0)) begin
            w_nxt_cnt    = CNT_W'(r_cnt - CNT_W'(1));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hit_q  <= 1'b0;
            r_health <= MAX_HEALTH;
            r_dead   <= 1'b0;
            r_cnt    <= '0;
            r_invuln <= 1'b0;
        end else begin
            r_hit_q  <= i_hit;
            r_health <= w_nxt_health;
            r_dead   <= w_nxt_dead;
            r_cnt    <= w_nxt_cnt;
            r_invuln <= (w_nxt_cnt != '0);
        end
    end

    assign o_health = r_health;
    assign o_dead   = r_dead;
    assign o_invuln = r_invuln;
endmodule

module health_tracker #(
    parameter logic [6:0] MAX_HEALTH    = 7'd100,
    parameter logic [6:0] DAMAGE        = 7'd10,
    parameter logic [5:0] INVULN_FRAMES = 6'd30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       battle_l,
    input  logic       Restart,
    input  logic       Player_Hit,
    input  logic       NPC_Hit,
    output logic [6:0] Player_Health,
    output logic [6:0] NPC_Health,
    output logic       Player_Dead,
    output logic       NPC_Dead,
    output logic       Player_Invuln,
    output logic       NPC_Invuln
);
    logic r_frame_q;
    logic w_frame_tick;

    // frame_clk is sampled as data; its rising edge yields a one-cycle tick
    always_ff @(posedge Clk) begin
        if (Reset) r_frame_q <= 1'b0;
        else       r_frame_q <= frame_clk;
    end

    assign w_frame_tick = frame_clk & ~r_frame_q;

    health_tracker_fighter #(
        .MAX_HEALTH(MAX_HEALTH), .DAMAGE(DAMAGE), .INVULN_FRAMES(INVULN_FRAMES)
    ) u_player (
        .i_clk(Clk), .i_reset(Reset), .i_restart(Restart), .i_battle(battle_l),
        .i_frame_tick(w_frame_tick), .i_hit(Player_Hit),
        .o_health(Player_Health), .o_dead(Player_Dead), .o_invuln(Player_Invuln)
    );

    health_tracker_fighter #(
        .MAX_HEALTH(MAX_HEALTH), .DAMAGE(DAMAGE), .INVULN_FRAMES(INVULN_FRAMES)
    ) u_npc (
        .i_clk(Clk), .i_reset(Reset), .i_restart(Restart), .i_battle(battle_l),
        .i_frame_tick(w_frame_tick), .i_hit(NPC_Hit),
        .o_health(NPC_Health), .o_dead(NPC_Dead), .o_invuln(NPC_Invuln)
    );
endmodule

// File: doc/health_tracker.md
HEALTH_TRACKER -- requirements
Module: health_tracker

Interface
REQ-001 Parameter MAX_HEALTH, default 7'd100: health loaded at reset and restart.
REQ-002 Parameter DAMAGE, default 7'd10: health removed per counted hit.
REQ-003 Parameter INVULN_FRAMES, default 6'd30: frames of hit immunity after a counted hit.
REQ-004 Clk  in  1  system clock (50 MHz); the single clock for the block.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 frame_clk  in  1  vertical-sync level (VGA_VS); rising edge marks one frame.
REQ-007 battle_l  in  1  high while the battle stage is active.
REQ-008 Restart  in  1  level; restores both fighters without a full Reset.
REQ-009 Player_Hit  in  1  level; high while a projectile overlaps the player.
REQ-010 NPC_Hit  in  1  level; high while a projectile overlaps the NPC (hitbox contact).
REQ-011 Player_Health, NPC_Health  out  7 each  current health, 0..MAX_HEALTH.
REQ-012 Player_Dead, NPC_Dead  out  1 each  registered; high when the matching health is 0.
REQ-013 Player_Invuln, NPC_Invuln  out  1 each  high while the matching immunity counter is nonzero.

Function
REQ-014 Frame edge: frame_clk SHALL be registered once; frame_tick = frame_clk & ~frame_clk_q, one Clk cycle per rising edge.
REQ-015 Hit edge: each Hit input SHALL be registered once; hit_edge = Hit & ~Hit_q. Only edges count. A held contact SHALL count at most once.
REQ-016 Counted hit: hit_edge & battle_l & ~Dead & (immunity counter == 0) & ~Restart.
REQ-017 On a counted hit, health SHALL become health - DAMAGE if health >= DAMAGE, else 0. The counter never wraps below 0.
REQ-018 On a counted hit, the immunity counter SHALL load INVULN_FRAMES.
REQ-019 Latency: health, Dead and Invuln SHALL update on the same Clk edge that samples the hit edge. Outputs are visible 1 cycle after Hit rises.
REQ-020 The immunity counter SHALL decrement by 1 on each frame_tick while nonzero. It SHALL hold at 0.
REQ-021 A counted hit and a frame_tick in the same cycle: the load SHALL win, with no decrement that cycle.
REQ-022 Dead SHALL be set when health reaches 0. It SHALL stay sticky until Reset or Restart; further hits are ignored.
REQ-023 Player and NPC paths SHALL be independent. Simultaneous counted hits SHALL both apply. Both Dead may rise in the same cycle.
REQ-024 battle_l low: hits SHALL be ignored. Immunity counters SHALL continue to decrement. Health SHALL hold.
REQ-025 Restart high: each cycle, health SHALL load MAX_HEALTH, Dead SHALL clear, and immunity counters SHALL clear. Restart SHALL override any same-cycle hit.
REQ-026 Restart asserted mid-immunity or after death SHALL fully recover on the next edge.
REQ-027 All state SHALL be flip-flops clocked by Clk only. frame_clk SHALL never be used as a clock.

Reset
REQ-028 On Reset=1 at a Clk edge:
- Player_Health = NPC_Health = MAX_HEALTH
- Dead = 0
- Invuln = 0
- immunity counters = 0
- frame_clk_q = 0
- Hit_q = 0
REQ-029 Reset SHALL take priority over Restart and all hits. Reset mid-immunity SHALL clear the counters immediately.
REQ-030 A Hit held high through Reset release SHALL count as an edge on the first post-reset cycle if battle_l=1.

Verification
REQ-031 Reset, battle_l=1, NPC_Hit rises and holds 200 cycles -> NPC_Health 100->90 one cycle later; no further change; NPC_Invuln=1.
REQ-032 After REQ-031, pulse NPC_Hit 1 cycle each frame -> no damage for 30 frame_ticks. The next pulse gives NPC_Health=80 and NPC_Invuln reloads.
REQ-033 DAMAGE=7'd30, MAX_HEALTH=100, four spaced hits -> health 70, 40, 10, 0. NPC_Dead=1 on the fourth, no negative wrap. A fifth hit leaves health 0.
REQ-034 Player_Hit and NPC_Hit rise in the same cycle with both at 10 -> both Health=0 and both Dead=1 in the same cycle.
REQ-035 battle_l=0 plus hit edges -> health unchanged. Restart asserted with NPC_Dead=1 and a same-cycle hit -> NPC_Health=100, NPC_Dead=0, NPC_Invuln=0.
